// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access controller and its wait counter.
package mem_access_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_CAP  = 3'd4,
    S_DONE = 3'd5
  } memState_t;

  localparam int MAX_WAIT_STATES = 15;
  localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable 4-bit down-counter that times the read wait states; o_zero marks the last wait cycle.
module mem_wait_cnt
  import mem_access_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic [WAIT_CNT_W-1:0] i_loadVal,
  input  logic                  i_en,
  output logic                  o_zero
);

  logic [WAIT_CNT_W-1:0] r_count;

  // Counting stops at zero so an idle counter never wraps around.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the single-port synchronous RAM: owns MAR/MDR and sequences read/write strobes.
// Optional out-of-range detection on the upper address bits is enabled with MEM_ACCESS_RANGE_CHECK_EN.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int BITS        = 32,
  parameter int RAMSIZE     = 512,
  parameter int ADDR        = $clog2(RAMSIZE),
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req,
  input  logic            we,
  input  logic [31:0]     addr,
  input  logic [BITS-1:0] wdata,
  output logic            ready,
  output logic            done,
  output logic            err,
  output logic [BITS-1:0] rdata,
  output logic            ram_read,
  output logic            ram_write,
  output logic [ADDR-1:0] ram_address,
  output logic [BITS-1:0] ram_dataIn,
  input  logic [BITS-1:0] ram_dataOut
);

  // The counter is loaded in RD with one less than the wait count so WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  memState_t       r_state;
  logic [ADDR-1:0] r_mar;
  logic [BITS-1:0] r_mdr;
  logic            r_ready;
  logic            r_done;
  logic            r_err;
  logic            r_ramRead;
  logic            r_ramWrite;

  logic            w_rangeErr;
  logic            w_cntZero;
  logic            w_cntLoad;
  logic            w_cntEn;

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  assign w_rangeErr = |(addr >> ADDR);
`else
  logic w_unusedAddrHi;
  assign w_unusedAddrHi = |(addr >> ADDR);
  assign w_rangeErr     = 1'b0;
`endif

  assign w_cntLoad = (r_state == S_RD);
  assign w_cntEn   = (r_state == S_WAIT);

  mem_wait_cnt u_waitCnt (
    .i_clk    (clk),
    .i_clr    (clr),
    .i_load   (w_cntLoad),
    .i_loadVal(WAIT_LOAD),
    .i_en     (w_cntEn),
    .o_zero   (w_cntZero)
  );

  // Outputs are registered alongside the state so each strobe/flag is high exactly in its own state.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_mar      <= '0;
      r_mdr      <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ramRead  <= 1'b0;
      r_ramWrite <= 1'b0;
    end else begin
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ramRead  <= 1'b0;
      r_ramWrite <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!req) begin
            r_ready <= 1'b1;
          end else if (w_rangeErr) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_mar <= addr[ADDR-1:0];
            if (we) begin
              r_mdr      <= wdata;
              r_state    <= S_WR;
              r_ramWrite <= 1'b1;
            end else begin
              r_state   <= S_RD;
              r_ramRead <= 1'b1;
            end
          end
        end
        S_WR: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_RD: begin
          r_state <= (WAIT_STATES > 0) ? S_WAIT : S_CAP;
        end
        S_WAIT: begin
          if (w_cntZero) begin
            r_state <= S_CAP;
          end
        end
        S_CAP: begin
          r_mdr   <= ram_dataOut;
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign done        = r_done;
  assign err         = r_err;
  assign rdata       = r_mdr;
  assign ram_read    = r_ramRead;
  assign ram_write   = r_ramWrite;
  assign ram_address = r_mar;
  assign ram_dataIn  = r_mdr;

endmodule
